// File: rtl/key_expander.sv
// rtl/key_expander.sv - iterative AES-128/192/256 key schedule with a combinational round-key read port
// One schedule word per cycle into a cleared-on-reset buffer; keys_valid only after the final word lands.
module key_expander #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [Nk*32-1:0]  key,
   output logic              busy,
   output logic              keys_valid,
   input  logic [3:0]        rd_round,
   output logic [127:0]      round_key
);
   localparam int Nkb = Nk * 32;
   localparam int Nw  = 4 * (Nr + 1);
   localparam int IW  = $clog2(Nw);
   localparam int KW  = $clog2(Nk);

   if (Nr != Nk + 6 || !(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_params
      $error("key_expander: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
   end

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t          state_q;
   logic [IW-1:0]   i_q;
   logic [KW-1:0]   kmod_q;
   logic [7:0]      rcon_q;
   logic            busy_q;
   logic            valid_q;
   logic [31:0]     w_q [Nw];

   logic [31:0]     prev_w, back_w, sub_in, sub_out, word_d;
   logic [IW-1:0]   base;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254 by repeated squaring) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   always_comb begin
      prev_w  = w_q[i_q - IW'(1)];
      back_w  = w_q[i_q - IW'(Nk)];
      sub_in  = (kmod_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = sub_word(sub_in);
      if (kmod_q == '0)
         word_d = back_w ^ sub_out ^ {rcon_q, 24'h000000};
      else if (Nk == 8 && kmod_q == KW'(4))
         word_d = back_w ^ sub_out;
      else
         word_d = back_w ^ prev_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         kmod_q  <= '0;
         rcon_q  <= 8'h01;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int j = 0; j < Nw; j++) w_q[j] <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  for (int j = 0; j < Nk; j++) w_q[j] <= key[Nkb-1-32*j -: 32];
                  i_q     <= IW'(Nk);
                  kmod_q  <= '0;
                  rcon_q  <= 8'h01;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b0;
                  state_q <= EXPAND;
               end
            end
            EXPAND: begin
               w_q[i_q] <= word_d;
               i_q      <= i_q + IW'(1);
               kmod_q   <= (kmod_q == KW'(Nk - 1)) ? '0 : kmod_q + KW'(1);
               if (kmod_q == '0)
                  rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               if (i_q == IW'(Nw - 1)) begin
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      base      = IW'({rd_round, 2'b00});
      round_key = '0;
      if (rd_round <= 4'(Nr))
         round_key = {w_q[base], w_q[base + IW'(1)], w_q[base + IW'(2)], w_q[base + IW'(3)]};
   end

   assign busy       = busy_q;
   assign keys_valid = valid_q;

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - bench for key_expander at Nk=4/6/8 against a FIPS-197 reference schedule
module tb_key_expander;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         st4, st6, st8;
   logic [127:0] k4;
   logic [191:0] k6;
   logic [255:0] k8;
   logic [3:0]   rd4, rd6, rd8;
   logic         b4, b6, b8, v4, v6, v8;
   logic [127:0] rk4, rk6, rk8;

   always #5 clk = ~clk;

   key_expander #(.Nk(4), .Nr(10)) u_k128 (.clk(clk), .rst_n(rst_n), .start(st4), .key(k4),
      .busy(b4), .keys_valid(v4), .rd_round(rd4), .round_key(rk4));
   key_expander #(.Nk(6), .Nr(12)) u_k192 (.clk(clk), .rst_n(rst_n), .start(st6), .key(k6),
      .busy(b6), .keys_valid(v6), .rd_round(rd6), .round_key(rk6));
   key_expander #(.Nk(8), .Nr(14)) u_k256 (.clk(clk), .rst_n(rst_n), .start(st8), .key(k8),
      .busy(b8), .keys_valid(v8), .rd_round(rd8), .round_key(rk8));

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0]  sbox_tab [256];
   logic [31:0] ref_w [60];
   logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Polynomial product then reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, c, s;
      c = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (tb_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_tab[a] = s;
      end
   endtask

   function automatic logic [31:0] tb_subw(input logic [31:0] x);
      return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
   endfunction

   // key is left-aligned: word j of the cipher key is key[255-32j -: 32]
   task automatic ref_expand(input int nk, input logic [255:0] key);
      logic [31:0] t;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) ref_w[i] = key[255-32*i -: 32];
         else begin
            t = ref_w[i-1];
            if (i % nk == 0) t = tb_subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
            else if (nk == 8 && i % nk == 4) t = tb_subw(t);
            ref_w[i] = ref_w[i-nk] ^ t;
         end
      end
   endtask

   task automatic drive(input int nk, input logic s, input logic [255:0] key);
      case (nk)
         4: begin st4 = s; k4 = key[255:128]; end
         6: begin st6 = s; k6 = key[255:64]; end
         default: begin st8 = s; k8 = key; end
      endcase
   endtask

   function automatic logic get_v(input int nk);
      case (nk) 4: return v4; 6: return v6; default: return v8; endcase
   endfunction

   function automatic logic get_b(input int nk);
      case (nk) 4: return b4; 6: return b6; default: return b8; endcase
   endfunction

   task automatic read_rk(input int nk, input int r, output logic [127:0] v);
      case (nk) 4: rd4 = 4'(r); 6: rd6 = 4'(r); default: rd8 = 4'(r); endcase
      #1;
      case (nk) 4: v = rk4; 6: v = rk6; default: v = rk8; endcase
   endtask

   task automatic verify_rounds(input int nk, input string tag);
      logic [127:0] v, e;
      for (int r = 0; r < 16; r++) begin
         read_rk(nk, r, v);
         e = '0;
         if (r <= nk + 6) e = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
         check_eq($sformatf("%s_rk%0d", tag, r), v, e);
      end
   endtask

   // Starts an expansion; glitch >= 0 pulses start with a different key that many cycles in.
   task automatic run_expand(input int nk, input logic [255:0] key, input int glitch, input string tag);
      int lat, bcnt;
      drive(nk, 1'b1, key);
      @(posedge clk); #1;
      check_eq({tag, "_busy_on"}, 128'(get_b(nk)), 128'(1));
      check_eq({tag, "_valid_drop"}, 128'(get_v(nk)), 128'(0));
      drive(nk, 1'b0, key);
      lat  = 0;
      bcnt = 1;
      while (!get_v(nk) && lat < 200) begin
         if (lat == glitch) drive(nk, 1'b1, ~key);
         else drive(nk, 1'b0, key);
         @(posedge clk); #1;
         lat++;
         if (get_b(nk)) bcnt++;
      end
      drive(nk, 1'b0, key);
      check_eq({tag, "_latency"}, 128'(lat), 128'(4 * (nk + 7) - nk));
      check_eq({tag, "_busy_cycles"}, 128'(bcnt), 128'(4 * (nk + 7) - nk));
      ref_expand(nk, key);
      verify_rounds(nk, tag);
   endtask

   initial begin
      logic [127:0] v;
      logic [255:0] rkey;
      int seen;
      rst_n = 1'b0;
      st4 = 1'b0; st6 = 1'b0; st8 = 1'b0;
      k4 = '0; k6 = '0; k8 = '0;
      rd4 = '0; rd6 = '0; rd8 = '0;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 128'({b4, b6, b8}), 128'(0));
      check_eq("rst_valid", 128'({v4, v6, v8}), 128'(0));
      for (int r = 0; r < 16; r++) begin
         read_rk(4, r, v); check_eq($sformatf("rst_rk4_%0d", r), v, '0);
         read_rk(6, r, v); check_eq($sformatf("rst_rk6_%0d", r), v, '0);
         read_rk(8, r, v); check_eq($sformatf("rst_rk8_%0d", r), v, '0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_expand(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, -1, "kat128a");
      read_rk(4, 1, v);  check_eq("kat128a_const_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(4, 10, v); check_eq("kat128a_const_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, -1, "kat128b");
      read_rk(4, 0, v);  check_eq("kat128b_const_rk0", v, 128'h000102030405060708090a0b0c0d0e0f);
      read_rk(4, 10, v); check_eq("kat128b_const_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      run_expand(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, -1, "kat192");
      read_rk(6, 12, v); check_eq("kat192_const_rk12", v, 128'he98ba06f448c773c8ecc720401002202);

      run_expand(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, -1, "kat256");
      read_rk(8, 14, v); check_eq("kat256_const_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);
      read_rk(8, 15, v); check_eq("kat256_rd15", v, '0);

      for (int n = 0; n < 3; n++) begin
         for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 8; j++) rkey[255-32*j -: 32] = $urandom();
            if (n == 0) rkey[127:0] = '0;
            if (n == 1) rkey[63:0] = '0;
            run_expand(4 + 2 * n, rkey, (t == 1) ? 10 + 3 * n : -1, $sformatf("rnd%0d_%0d", 4 + 2 * n, t));
         end
      end

      for (int j = 0; j < 8; j++) rkey[255-32*j -: 32] = $urandom();
      drive(8, 1'b1, rkey);
      @(posedge clk); #1;
      drive(8, 1'b0, rkey);
      repeat (20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #2;
      check_eq("abort_busy", 128'(b8), 128'(0));
      check_eq("abort_valid", 128'(v8), 128'(0));
      read_rk(8, 0, v); check_eq("abort_rk0", v, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (v8 || b8) seen++;
      end
      check_eq("abort_stays_idle", 128'(seen), 128'(0));
      run_expand(8, rkey, -1, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
